// File: rtl/drop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : drop_ctrl_pkg
//  Purpose  : Shared definitions for the gravity/drop controller: FSM state
//             encoding and default sizing parameters.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package drop_ctrl_pkg;

  // Cycles a grounded piece waits before locking (0.5 s at 100 MHz).
  localparam int unsigned LOCK_DELAY_DEFAULT = 50_000_000;

  // Width of the hard-drop row counter.
  localparam int unsigned ROWS_LEN_DEFAULT   = 5;

  // Drop controller states, explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_COMMIT = 3'd2,
    ST_GROUND = 3'd3,
    ST_LOCK   = 3'd4
  } state_e;

endpackage : drop_ctrl_pkg
`default_nettype wire

// File: rtl/drop_ctrl_lock_timer.sv
`default_nettype none
// ============================================================================
//  Module   : lock_timer
//  Purpose  : Lock-delay counter for a grounded piece. Counts up from zero
//             while enabled and flags 'expired' when the count reaches
//             LOCK_DELAY-1, so a caller that acts on 'expired' in a registered
//             FSM sees its action exactly LOCK_DELAY cycles after the count
//             started.
//  Ports    : clk     - system clock
//             rst     - asynchronous active-high reset
//             clear   - synchronous clear to zero (dominates enable)
//             enable  - count one per cycle
//             expired - count == LOCK_DELAY-1
//  Revision : 1.0 - initial release
// ============================================================================
module lock_timer
  import drop_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_DELAY = LOCK_DELAY_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Counter only has to reach LOCK_DELAY-1; guard the degenerate delay of 1.
  localparam int unsigned     CNT_W    = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DELAY - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      // Hold at the terminal count rather than wrapping.
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : lock_timer
`default_nettype wire

// File: rtl/drop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : drop_ctrl
//  Purpose  : Gravity/drop controller. Turns fall-timer expiry and soft/hard
//             drop keys into a request/acknowledge descent test with the
//             board, then commits the move or grounds the piece, runs the
//             lock delay and locks it. Pulses fall_rst after every committed
//             gravity/soft step and after every lock.
//  Ports    : clk          in  - system clock
//             rst          in  - asynchronous active-high reset
//             game_active  in  - low freezes gameplay
//             timeout      in  - fall timer expired (level)
//             soft_drop    in  - one-cycle key pulse
//             hard_drop    in  - one-cycle key pulse
//             piece_moved  in  - one-cycle pulse, lateral move/rotation done
//             mv_req       out - ask board to test piece at y+1
//             mv_ack       in  - one-cycle pulse, test result valid
//             mv_ok        in  - test result, 1 = descent legal
//             commit       out - one-cycle pulse, board applies y+1
//             lock         out - one-cycle pulse, board writes piece
//             fall_rst     out - one-cycle pulse to fall timer reset
//             rows_dropped out - rows descended by last hard drop (with lock)
//             busy         out - controller not idle
//  Revision : 1.0 - initial release
// ============================================================================
module drop_ctrl
  import drop_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_DELAY = LOCK_DELAY_DEFAULT,
  parameter int unsigned ROWS_LEN   = ROWS_LEN_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                game_active,
  input  logic                timeout,
  input  logic                soft_drop,
  input  logic                hard_drop,
  input  logic                piece_moved,
  output logic                mv_req,
  input  logic                mv_ack,
  input  logic                mv_ok,
  output logic                commit,
  output logic                lock,
  output logic                fall_rst,
  output logic [ROWS_LEN-1:0] rows_dropped,
  output logic                busy
);

  localparam logic [ROWS_LEN-1:0] ROWS_MAX = '1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic                hard_q, hard_d;     // current sequence is a hard drop
  logic [ROWS_LEN-1:0] rows_q, rows_d;     // rows committed by this hard drop
  logic                guard_q;            // fall_rst was high last cycle

  // Registered outputs, loaded from the next state so every output is a flop.
  logic                mv_req_q,   mv_req_d;
  logic                commit_q,   commit_d;
  logic                lock_q,     lock_d;
  logic                fall_rst_q, fall_rst_d;
  logic                busy_q,     busy_d;
  logic [ROWS_LEN-1:0] rows_out_q, rows_out_d;

  logic                lock_expired;
  logic                timer_clear;
  logic                timer_en;

  // --------------------------------------------------------------------------
  // Lock delay timer: held at zero outside GROUND, so GROUND entry always
  // starts from a fresh count and leaving GROUND discards any progress.
  // --------------------------------------------------------------------------
  assign timer_clear = (state_q != ST_GROUND);
  assign timer_en    = (state_q == ST_GROUND);

  lock_timer #(
    .LOCK_DELAY (LOCK_DELAY)
  ) u_lock_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (lock_expired)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hard_d  = hard_q;
    rows_d  = rows_q;

    case (state_q)
      ST_IDLE: begin
        if (game_active) begin
          if (hard_drop) begin
            state_d = ST_REQ;
            hard_d  = 1'b1;
            rows_d  = '0;
          end else if (soft_drop || (timeout && !guard_q)) begin
            // timeout is still high the cycle after fall_rst because the
            // fall timer has not yet seen its reset; guard_q masks it.
            state_d = ST_REQ;
            hard_d  = 1'b0;
          end
        end
      end

      ST_REQ: begin
        // The handshake is always completed, even when gameplay freezes,
        // so the board never sees a request withdrawn mid-test.
        if (mv_ack) begin
          if (!game_active) begin
            state_d = ST_IDLE;
          end else if (mv_ok) begin
            state_d = ST_COMMIT;
          end else if (hard_q) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_GROUND;
          end
        end
      end

      ST_COMMIT: begin
        if (hard_q) begin
          if (rows_q != ROWS_MAX) begin
            rows_d = rows_q + 1'b1;
          end
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GROUND: begin
        if (!game_active || piece_moved) begin
          state_d = ST_IDLE;
        end else if (hard_drop || lock_expired) begin
          state_d = ST_LOCK;
        end
      end

      ST_LOCK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state (registered below)
  // --------------------------------------------------------------------------
  always_comb begin
    mv_req_d   = (state_d == ST_REQ);
    commit_d   = (state_d == ST_COMMIT);
    lock_d     = (state_d == ST_LOCK);
    busy_d     = (state_d != ST_IDLE);
    // A hard drop restarts gravity only once, at its final lock.
    fall_rst_d = ((state_d == ST_COMMIT) && !hard_d) || (state_d == ST_LOCK);
    rows_out_d = ((state_d == ST_LOCK) && hard_d) ? rows_d : '0;
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hard_q     <= 1'b0;
      rows_q     <= '0;
      guard_q    <= 1'b0;
      mv_req_q   <= 1'b0;
      commit_q   <= 1'b0;
      lock_q     <= 1'b0;
      fall_rst_q <= 1'b0;
      busy_q     <= 1'b0;
      rows_out_q <= '0;
    end else begin
      state_q    <= state_d;
      hard_q     <= hard_d;
      rows_q     <= rows_d;
      guard_q    <= fall_rst_q;
      mv_req_q   <= mv_req_d;
      commit_q   <= commit_d;
      lock_q     <= lock_d;
      fall_rst_q <= fall_rst_d;
      busy_q     <= busy_d;
      rows_out_q <= rows_out_d;
    end
  end

  assign mv_req       = mv_req_q;
  assign commit       = commit_q;
  assign lock         = lock_q;
  assign fall_rst     = fall_rst_q;
  assign busy         = busy_q;
  assign rows_dropped = rows_out_q;

endmodule : drop_ctrl
`default_nettype wire

// File: tb/tb_drop_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_drop_ctrl
//  Purpose  : Self-checking bench for drop_ctrl: directed scenarios with
//             literal expectations plus a randomized run, all compared every
//             cycle against a behavioural model of the controller.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_drop_ctrl;

  localparam int LD      = 8;
  localparam int RL      = 5;
  localparam int ROWSMAX = (1 << RL) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          game_active, timeout, soft_drop, hard_drop, piece_moved;
  logic          mv_ack, mv_ok;
  logic          mv_req, commit, lock, fall_rst, busy;
  logic [RL-1:0] rows_dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  drop_ctrl #(
    .LOCK_DELAY (LD),
    .ROWS_LEN   (RL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_active  (game_active),
    .timeout      (timeout),
    .soft_drop    (soft_drop),
    .hard_drop    (hard_drop),
    .piece_moved  (piece_moved),
    .mv_req       (mv_req),
    .mv_ack       (mv_ack),
    .mv_ok        (mv_ok),
    .commit       (commit),
    .lock         (lock),
    .fall_rst     (fall_rst),
    .rows_dropped (rows_dropped),
    .busy         (busy)
  );

  // --------------------------------------------------------------------------
  // Behavioural model: what the controller is doing this cycle, described as
  // "waiting on the board", "grounded for N cycles", "committing", "locking".
  // --------------------------------------------------------------------------
  bit m_req, m_commit, m_lock, m_hard, m_guard;
  int m_age;   // cycles spent grounded, -1 when not grounded
  int m_rows;

  task automatic model_reset();
    m_req = 0; m_commit = 0; m_lock = 0; m_hard = 0; m_guard = 0;
    m_age = -1; m_rows = 0;
  endtask

  function automatic bit m_fall();
    return (m_commit && !m_hard) || m_lock;
  endfunction

  function automatic bit m_busy();
    return m_req || m_commit || m_lock || (m_age >= 0);
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit fr;
    fr = m_fall();
    if (m_lock) begin
      m_lock = 0;
    end else if (m_commit) begin
      m_commit = 0;
      if (m_hard) begin
        if (m_rows < ROWSMAX) m_rows++;
        m_req = 1;
      end
    end else if (m_req) begin
      if (mv_ack) begin
        m_req = 0;
        if (game_active) begin
          if (mv_ok)       m_commit = 1;
          else if (m_hard) m_lock   = 1;
          else             m_age    = 0;
        end
      end
    end else if (m_age >= 0) begin
      if (!game_active || piece_moved) begin
        m_age = -1;
      end else if (hard_drop || m_age == LD - 1) begin
        m_age  = -1;
        m_lock = 1;
      end else begin
        m_age++;
      end
    end else if (game_active) begin
      if (hard_drop) begin
        m_req = 1; m_hard = 1; m_rows = 0;
      end else if (soft_drop || (timeout && !m_guard)) begin
        m_req = 1; m_hard = 0;
      end
    end
    m_guard = fr;
  endtask

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    int exp_rows;
    exp_rows = (m_lock && m_hard) ? m_rows : 0;
    chk("mv_req",       {31'd0, mv_req},   {31'd0, m_req});
    chk("commit",       {31'd0, commit},   {31'd0, m_commit});
    chk("lock",         {31'd0, lock},     {31'd0, m_lock});
    chk("fall_rst",     {31'd0, fall_rst}, {31'd0, m_fall()});
    chk("busy",         {31'd0, busy},     {31'd0, m_busy()});
    chk("rows_dropped", {27'd0, rows_dropped}, exp_rows);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // then key/handshake pulses are withdrawn.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
    cyc++;
    mv_ack = 0; mv_ok = 0; soft_drop = 0; hard_drop = 0; piece_moved = 0;
  endtask

  // Bound on total run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int nfall;
    int grav;
    bit fr1, fr2;

    rst = 1; game_active = 0; timeout = 0; soft_drop = 0; hard_drop = 0;
    piece_moved = 0; mv_ack = 0; mv_ok = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_mv_req",   {31'd0, mv_req},   0);
    chk("rst_commit",   {31'd0, commit},   0);
    chk("rst_lock",     {31'd0, lock},     0);
    chk("rst_fall_rst", {31'd0, fall_rst}, 0);
    chk("rst_busy",     {31'd0, busy},     0);
    chk("rst_rows",     {27'd0, rows_dropped}, 0);
    @(posedge clk); #1;
    rst = 0;
    step();

    // Gravity step, legal; timeout lingers one cycle past fall_rst.
    game_active = 1; timeout = 1;
    step(); chk("grav_req", {31'd0, mv_req}, 1);
    mv_ack = 1; mv_ok = 1;
    step(); chk("grav_commit", {31'd0, commit}, 1); chk("grav_fall", {31'd0, fall_rst}, 1);
    step(); chk("grav_idle", {31'd0, busy}, 0);
    step(); chk("grav_guard_noreq", {31'd0, mv_req}, 0);
    timeout = 0;
    step();

    // Grounded lock after exactly LD cycles.
    timeout = 1;
    step(); chk("gnd_req", {31'd0, mv_req}, 1);
    timeout = 0; mv_ack = 1; mv_ok = 0;
    step(); chk("gnd_busy", {31'd0, busy}, 1);
    for (int i = 1; i <= LD; i++) begin
      step();
      if (i < LD) chk("gnd_wait_nolock", {31'd0, lock}, 0);
    end
    chk("gnd_lock", {31'd0, lock}, 1);
    chk("gnd_lock_fall", {31'd0, fall_rst}, 1);
    chk("gnd_lock_rows", {27'd0, rows_dropped}, 0);
    step();

    // piece_moved at ground cycle 5 cancels the lock.
    timeout = 1;
    step();
    timeout = 0; mv_ack = 1; mv_ok = 0;
    step();
    repeat (5) step();
    piece_moved = 1;
    step(); chk("lrst_idle", {31'd0, busy}, 0);
    repeat (10) begin
      step(); chk("lrst_nolock", {31'd0, lock}, 0);
    end
    timeout = 1;
    step(); chk("lrst_fresh_req", {31'd0, mv_req}, 1);
    timeout = 0; mv_ack = 1; mv_ok = 1;
    step();
    repeat (2) step();

    // Hard drop: three legal rows then blocked.
    nfall = 0;
    hard_drop = 1;
    step(); chk("hd_req", {31'd0, mv_req}, 1);
    for (int k = 0; k < 3; k++) begin
      mv_ack = 1; mv_ok = 1;
      step(); chk("hd_commit", {31'd0, commit}, 1); nfall += int'(fall_rst);
      step(); chk("hd_rereq", {31'd0, mv_req}, 1); nfall += int'(fall_rst);
    end
    mv_ack = 1; mv_ok = 0;
    step();
    chk("hd_lock", {31'd0, lock}, 1);
    chk("hd_rows", {27'd0, rows_dropped}, 3);
    nfall += int'(fall_rst);
    chk("hd_fall_count", nfall, 1);
    step();

    // Priority: hard_drop and timeout together take the hard path.
    hard_drop = 1; timeout = 1;
    step(); chk("prio_req", {31'd0, mv_req}, 1);
    timeout = 0; mv_ack = 1; mv_ok = 0;
    step(); chk("prio_lock", {31'd0, lock}, 1);
    repeat (2) step();

    // Row counter saturation.
    hard_drop = 1;
    step();
    repeat (ROWSMAX + 2) begin
      mv_ack = 1; mv_ok = 1;
      step(); step();
    end
    mv_ack = 1; mv_ok = 0;
    step(); chk("sat_rows", {27'd0, rows_dropped}, ROWSMAX);
    repeat (2) step();

    // Gameplay frozen mid-request: handshake completes, nothing applied.
    timeout = 1;
    step();
    timeout = 0; game_active = 0;
    step(); step(); chk("ga_hold_req", {31'd0, mv_req}, 1);
    mv_ack = 1; mv_ok = 1;
    step(); chk("ga_nocommit", {31'd0, commit}, 0); chk("ga_idle", {31'd0, busy}, 0);
    game_active = 1;
    // Frozen while grounded.
    timeout = 1;
    step();
    timeout = 0; mv_ack = 1; mv_ok = 0;
    step();
    game_active = 0;
    step(); chk("ga_gnd_idle", {31'd0, busy}, 0);
    game_active = 1;
    repeat (LD + 2) step();

    // Asynchronous reset mid-request.
    timeout = 1;
    step(); chk("arst_req_before", {31'd0, mv_req}, 1);
    timeout = 0;
    #3 rst = 1;
    #1;
    chk("arst_mv_req", {31'd0, mv_req}, 0);
    chk("arst_busy",   {31'd0, busy},   0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    step();
    chk("arst_after_busy", {31'd0, busy}, 0);

    // Randomized run with a board responder and a simple fall timer.
    game_active = 1; timeout = 0; grav = 5; fr1 = 0; fr2 = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      if (mv_req && $urandom_range(0, 2) == 0) begin
        mv_ack = 1; mv_ok = ($urandom_range(0, 9) < 7);
      end else if ($urandom_range(0, 19) == 0) begin
        mv_ack = 1; mv_ok = ($urandom_range(0, 1) == 1);
      end
      soft_drop   = ($urandom_range(0, 29) == 0);
      hard_drop   = ($urandom_range(0, 59) == 0);
      piece_moved = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 149) == 0) game_active = ~game_active;
      // Fall timer drops timeout one cycle late after its reset.
      fr2 = fr1; fr1 = fall_rst;
      if (fr2) begin
        timeout = 0; grav = $urandom_range(2, 25);
      end else if (grav > 0) begin
        grav--;
      end else begin
        timeout = 1;
      end
      step();
      if (rst) begin
        #2 rst = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_drop_ctrl
`default_nettype wire
